// File: rtl/vga_pkg.sv
// Geometry, control codes and state encoding shared by the text writer
// and the display address generator.
package vga_pkg;

  localparam logic [15:0] FB_BASE     = 16'h3000;
  localparam int          ROW_STRIDE  = 80;
  localparam int          COLS        = 80;
  localparam int          ROWS        = 60;
  localparam logic [7:0]  BLANK_GLYPH = 8'h00;

  localparam logic [7:0]  CC_LF = 8'h0A;
  localparam logic [7:0]  CC_CR = 8'h0D;
  localparam logic [7:0]  CC_BS = 8'h08;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

endpackage

// File: rtl/fb_text_writer_if.sv
// Character stream, frame-buffer port and cursor status of the text writer.
// slave = writer side, master = feeder/memory side.
interface fb_text_writer_if #(parameter int ADDR_WIDTH = 16);

  logic                  char_valid;
  logic [7:0]            char_data;
  logic                  char_ready;
  logic                  clear_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_re;
  logic [15:0]           mem_rdata;
  logic                  mem_we;
  logic [15:0]           mem_wdata;
  logic [6:0]            cursor_col;
  logic [5:0]            cursor_row;
  logic                  busy;

  modport slave (
    input  char_valid, char_data, clear_req, mem_rdata,
    output char_ready, mem_addr, mem_re, mem_we, mem_wdata,
           cursor_col, cursor_row, busy
  );

  modport master (
    output char_valid, char_data, clear_req, mem_rdata,
    input  char_ready, mem_addr, mem_re, mem_we, mem_wdata,
           cursor_col, cursor_row, busy
  );

endinterface

// File: rtl/fb_addr_calc.sv
// Glyph cell (row, col) to frame-buffer word address and byte select
// (0 = [15:8], 1 = [7:0]); wraps modulo 2^ADDR_WIDTH.
module fb_addr_calc
  import vga_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic [5:0]            i_row,
  input  logic [6:0]            i_col,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_byte_sel
);

  assign o_addr     = ADDR_WIDTH'(int'(FB_BASE) + ROW_STRIDE * int'(i_row) + int'(i_col[6:1]));
  assign o_byte_sel = i_col[0];

endmodule

// File: rtl/fb_text_writer.sv
// Text cursor and read-modify-write glyph writer with full-screen clear.
// Optional macro FB_TEXT_WRITER_CLEAR_ON_WRAP_EN: wrapping past the last row clears the screen.
//
// state    | meaning
// IDLE     | accept a byte or a clear request; control codes finish here
// READ     | fetch the word holding the cursor cell
// WRITE    | write back with the glyph merged in, advance cursor
// CLEAR    | blank every word, one per cycle, then home the cursor
module fb_text_writer
  import vga_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  fb_text_writer_if.slave  bus
);

`ifdef FB_TEXT_WRITER_CLEAR_ON_WRAP_EN
  localparam logic CLEAR_ON_WRAP = 1'b1;
`else
  localparam logic CLEAR_ON_WRAP = 1'b0;
`endif

  state_t r_state, w_state_nxt;
  logic [6:0] r_col, w_col_nxt;
  logic [5:0] r_row, w_row_nxt;
  logic [7:0] r_char, w_char_nxt;
  logic [5:0] r_clr_row, w_clr_row_nxt;
  logic [5:0] r_clr_word, w_clr_word_nxt;

  logic                  w_ready, w_re, w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [15:0]           w_wdata;

  logic [5:0]            w_calc_row;
  logic [6:0]            w_calc_col;
  logic [ADDR_WIDTH-1:0] w_calc_addr;
  logic                  w_byte_sel;

  logic       w_row_wrap, w_wrap_clear;
  logic [5:0] w_row_inc;

  // The clear sweep shares the address calculator with the cursor path.
  assign w_calc_row = (r_state == ST_CLEAR) ? r_clr_row : r_row;
  assign w_calc_col = (r_state == ST_CLEAR) ? {r_clr_word, 1'b0} : r_col;

  fb_addr_calc #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_calc (
    .i_row      (w_calc_row),
    .i_col      (w_calc_col),
    .o_addr     (w_calc_addr),
    .o_byte_sel (w_byte_sel)
  );

  assign w_row_wrap   = (r_row == 6'(ROWS - 1));
  assign w_row_inc    = w_row_wrap ? 6'd0 : r_row + 6'd1;
  assign w_wrap_clear = CLEAR_ON_WRAP & w_row_wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_col      <= '0;
      r_row      <= '0;
      r_char     <= '0;
      r_clr_row  <= '0;
      r_clr_word <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_col      <= w_col_nxt;
      r_row      <= w_row_nxt;
      r_char     <= w_char_nxt;
      r_clr_row  <= w_clr_row_nxt;
      r_clr_word <= w_clr_word_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_col_nxt      = r_col;
    w_row_nxt      = r_row;
    w_char_nxt     = r_char;
    w_clr_row_nxt  = r_clr_row;
    w_clr_word_nxt = r_clr_word;
    w_ready        = 1'b0;
    w_re           = 1'b0;
    w_we           = 1'b0;
    w_addr         = '0;
    w_wdata        = '0;

    unique case (r_state)
      ST_IDLE: begin
        // Gated by reset so the feeder sees not-ready while reset is held.
        w_ready = reset & ~bus.clear_req;
        if (bus.clear_req) begin
          w_state_nxt = ST_CLEAR;
        end else if (bus.char_valid) begin
          unique case (bus.char_data)
            CC_LF: begin
              w_col_nxt = '0;
              w_row_nxt = w_row_inc;
              if (w_wrap_clear) w_state_nxt = ST_CLEAR;
            end
            CC_CR: w_col_nxt = '0;
            CC_BS: w_col_nxt = (r_col == 7'd0) ? 7'd0 : r_col - 7'd1;
            default: begin
              w_char_nxt  = bus.char_data;
              w_state_nxt = ST_READ;
            end
          endcase
        end
      end

      ST_READ: begin
        w_re        = 1'b1;
        w_addr      = w_calc_addr;
        w_state_nxt = ST_WRITE;
      end

      ST_WRITE: begin
        w_we        = 1'b1;
        w_addr      = w_calc_addr;
        w_wdata     = w_byte_sel ? {bus.mem_rdata[15:8], r_char}
                                 : {r_char, bus.mem_rdata[7:0]};
        w_state_nxt = ST_IDLE;
        if (r_col == 7'(COLS - 1)) begin
          w_col_nxt = '0;
          w_row_nxt = w_row_inc;
          if (w_wrap_clear) w_state_nxt = ST_CLEAR;
        end else begin
          w_col_nxt = r_col + 7'd1;
        end
      end

      ST_CLEAR: begin
        w_we    = 1'b1;
        w_addr  = w_calc_addr;
        w_wdata = {BLANK_GLYPH, BLANK_GLYPH};
        // Counters return to zero at the end so the next clear starts at (0,0).
        if (r_clr_word == 6'(COLS / 2 - 1)) begin
          w_clr_word_nxt = '0;
          if (r_clr_row == 6'(ROWS - 1)) begin
            w_clr_row_nxt = '0;
            w_col_nxt     = '0;
            w_row_nxt     = '0;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_clr_row_nxt = r_clr_row + 6'd1;
          end
        end else begin
          w_clr_word_nxt = r_clr_word + 6'd1;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.char_ready = w_ready;
  assign bus.mem_re     = w_re;
  assign bus.mem_we     = w_we;
  assign bus.mem_addr   = w_addr;
  assign bus.mem_wdata  = w_wdata;
  assign bus.cursor_col = r_col;
  assign bus.cursor_row = r_row;
  assign bus.busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fb_text_writer.sv
// Randomized bench for fb_text_writer against a cursor/screen reference model.
module tb_fb_text_writer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   m_row = 0;
  int   m_col = 0;

`ifdef FB_TEXT_WRITER_CLEAR_ON_WRAP_EN
  localparam bit CLEAR_ON_WRAP = 1'b1;
`else
  localparam bit CLEAR_ON_WRAP = 1'b0;
`endif

  fb_text_writer_if #(.ADDR_WIDTH(16)) fb_if ();

  fb_text_writer #(.ADDR_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (fb_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 3ms", $time);
    $fatal(1);
  end

  function automatic logic [15:0] exp_addr(input int r, input int c);
    return 16'((32'h3000 + 80 * r + c / 2) & 32'hFFFF);
  endfunction

  task automatic model_newline(output bit goes_clear);
    goes_clear = 1'b0;
    if (m_row == 59) begin
      m_row = 0;
      goes_clear = CLEAR_ON_WRAP;
    end else begin
      m_row = m_row + 1;
    end
  endtask

  // Expects to be called at negedge+1 of the first CLEAR cycle.
  task automatic check_clear(input string tag);
    logic [35:0] got, exp;
    for (int i = 0; i < 2400; i++) begin
      if (i > 0) begin
        @(negedge clk); #1;
      end
      got = {fb_if.mem_we, fb_if.mem_re, fb_if.char_ready, fb_if.busy, fb_if.mem_addr, fb_if.mem_wdata};
      exp = {1'b1, 1'b0, 1'b0, 1'b1, exp_addr(i / 40, 2 * (i % 40)), 16'h0000};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s_write%0d: got we/re/rdy/busy/addr/wdata %h required %h", tag, i, got, exp);
      end
    end
    @(negedge clk); #1;
    m_row = 0;
    m_col = 0;
    n_cmp++;
    if ({fb_if.busy, fb_if.mem_we, fb_if.cursor_row, fb_if.cursor_col} !== {1'b0, 1'b0, 6'd0, 7'd0}) begin
      n_err++;
      $display("FAIL %s_done: got busy=%b we=%b cursor=(%0d,%0d) required busy=0 we=0 cursor=(0,0)",
               tag, fb_if.busy, fb_if.mem_we, fb_if.cursor_row, fb_if.cursor_col);
    end
  endtask

  // Called at negedge+1 with the DUT idle; returns at negedge+1 once the byte has been fully handled.
  task automatic send_byte(input logic [7:0] b, input logic [15:0] rd);
    int budget;
    bit clr;
    int r0, c0;
    logic [15:0] exp_w;
    fb_if.char_valid = 1'b1;
    fb_if.char_data  = b;
    budget = 0;
    while (fb_if.char_ready !== 1'b1 && budget < 5000) begin
      @(negedge clk); #1;
      budget++;
    end
    if (budget >= 5000) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got char_ready=%b required 1 within 5000 cycles", fb_if.char_ready);
      fb_if.char_valid = 1'b0;
      return;
    end
    @(negedge clk); #1;
    fb_if.char_valid = 1'b0;
    clr = 1'b0;
    if (b == 8'h0A || b == 8'h0D || b == 8'h08) begin
      if (b == 8'h0A) begin
        m_col = 0;
        model_newline(clr);
      end else if (b == 8'h0D) begin
        m_col = 0;
      end else if (m_col > 0) begin
        m_col = m_col - 1;
      end
      if (clr) begin
        check_clear("lf_wrap_clear");
      end else begin
        n_cmp++;
        if ({fb_if.mem_re, fb_if.mem_we, fb_if.busy, fb_if.char_ready, fb_if.cursor_row, fb_if.cursor_col}
            !== {1'b0, 1'b0, 1'b0, 1'b1, 6'(m_row), 7'(m_col)}) begin
          n_err++;
          $display("FAIL ctrl_%h: got re=%b we=%b busy=%b rdy=%b cursor=(%0d,%0d) required 0 0 0 1 (%0d,%0d)",
                   b, fb_if.mem_re, fb_if.mem_we, fb_if.busy, fb_if.char_ready,
                   fb_if.cursor_row, fb_if.cursor_col, m_row, m_col);
        end
      end
      return;
    end
    r0 = m_row;
    c0 = m_col;
    n_cmp++;
    if ({fb_if.mem_re, fb_if.mem_we, fb_if.char_ready, fb_if.busy, fb_if.mem_addr}
        !== {1'b1, 1'b0, 1'b0, 1'b1, exp_addr(r0, c0)}) begin
      n_err++;
      $display("FAIL read_phase: got re=%b we=%b rdy=%b busy=%b addr=%h required 1 0 0 1 %h",
               fb_if.mem_re, fb_if.mem_we, fb_if.char_ready, fb_if.busy, fb_if.mem_addr, exp_addr(r0, c0));
    end
    fb_if.mem_rdata = rd;
    @(negedge clk); #1;
    exp_w = (c0 % 2 == 1) ? {rd[15:8], b} : {b, rd[7:0]};
    n_cmp++;
    if ({fb_if.mem_re, fb_if.mem_we, fb_if.mem_addr, fb_if.mem_wdata}
        !== {1'b0, 1'b1, exp_addr(r0, c0), exp_w}) begin
      n_err++;
      $display("FAIL write_phase: got re=%b we=%b addr=%h wdata=%h required 0 1 %h %h",
               fb_if.mem_re, fb_if.mem_we, fb_if.mem_addr, fb_if.mem_wdata, exp_addr(r0, c0), exp_w);
    end
    fb_if.mem_rdata = 16'($urandom);
    if (m_col == 79) begin
      m_col = 0;
      model_newline(clr);
    end else begin
      m_col = m_col + 1;
    end
    @(negedge clk); #1;
    if (clr) begin
      check_clear("glyph_wrap_clear");
    end else begin
      n_cmp++;
      if ({fb_if.char_ready, fb_if.busy, fb_if.mem_we, fb_if.mem_re, fb_if.cursor_row, fb_if.cursor_col}
          !== {1'b1, 1'b0, 1'b0, 1'b0, 6'(m_row), 7'(m_col)}) begin
        n_err++;
        $display("FAIL glyph_done: got rdy=%b busy=%b we=%b re=%b cursor=(%0d,%0d) required 1 0 0 0 (%0d,%0d)",
                 fb_if.char_ready, fb_if.busy, fb_if.mem_we, fb_if.mem_re,
                 fb_if.cursor_row, fb_if.cursor_col, m_row, m_col);
      end
    end
  endtask

  function automatic logic [7:0] rand_glyph();
    return 8'($urandom_range(14, 255));
  endfunction

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk); #1;
    n_cmp++;
    if ({fb_if.char_ready, fb_if.busy, fb_if.mem_re, fb_if.mem_we, fb_if.mem_addr, fb_if.mem_wdata,
         fb_if.cursor_row, fb_if.cursor_col} !== 49'd0) begin
      n_err++;
      $display("FAIL in_reset: got rdy=%b busy=%b re=%b we=%b addr=%h wdata=%h cursor=(%0d,%0d) required all zero",
               fb_if.char_ready, fb_if.busy, fb_if.mem_re, fb_if.mem_we, fb_if.mem_addr, fb_if.mem_wdata,
               fb_if.cursor_row, fb_if.cursor_col);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({fb_if.char_ready, fb_if.busy, fb_if.cursor_row, fb_if.cursor_col} !== {1'b1, 1'b0, 13'd0}) begin
      n_err++;
      $display("FAIL after_release: got rdy=%b busy=%b cursor=(%0d,%0d) required 1 0 (0,0)",
               fb_if.char_ready, fb_if.busy, fb_if.cursor_row, fb_if.cursor_col);
    end
    m_row = 0;
    m_col = 0;
  endtask

  task automatic test_basic();
    send_byte(8'h41, 16'h2020);
    send_byte(8'h42, 16'h4120);
  endtask

  task automatic test_backspace();
    send_byte(8'h08, 16'h0);
    send_byte(8'h08, 16'h0);
    send_byte(8'h08, 16'h0);
    send_byte(rand_glyph(), 16'($urandom));
    send_byte(8'h08, 16'h0);
    send_byte(8'h0D, 16'h0);
  endtask

  task automatic test_row_end();
    for (int i = 0; i < 5; i++) send_byte(8'h0A, 16'h0);
    for (int i = 0; i < 79; i++) send_byte(rand_glyph(), 16'($urandom));
    send_byte(8'h55, 16'h1111);
  endtask

  task automatic test_wrap();
    send_byte(8'h0D, 16'h0);
    while (m_row != 59) send_byte(8'h0A, 16'h0);
    for (int i = 0; i < 10; i++) send_byte(rand_glyph(), 16'($urandom));
    send_byte(8'h0A, 16'h0);
  endtask

  task automatic test_clear_priority();
    logic [7:0] g;
    g = rand_glyph();
    fb_if.clear_req  = 1'b1;
    fb_if.char_valid = 1'b1;
    fb_if.char_data  = g;
    #1;
    n_cmp++;
    if (fb_if.char_ready !== 1'b0) begin
      n_err++;
      $display("FAIL clear_prio_ready: got char_ready=%b required 0", fb_if.char_ready);
    end
    @(negedge clk); #1;
    fb_if.clear_req = 1'b0;
    check_clear("clear_req");
    send_byte(g, 16'($urandom));
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = cyc;
    for (int i = 0; i < 3; i++) send_byte(rand_glyph(), 16'($urandom));
    n_cmp++;
    if (cyc - c0 != 9) begin
      n_err++;
      $display("FAIL back_to_back: got %0d cycles for 3 glyphs required 9", cyc - c0);
    end
  endtask

  task automatic test_random();
    int k;
    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 99);
      if (k < 10)      send_byte(8'h0A, 16'h0);
      else if (k < 15) send_byte(8'h0D, 16'h0);
      else if (k < 22) send_byte(8'h08, 16'h0);
      else             send_byte(rand_glyph(), 16'($urandom));
    end
  endtask

  task automatic test_reset_midwrite();
    bit saw_we;
    fb_if.char_valid = 1'b1;
    fb_if.char_data  = 8'h33;
    @(negedge clk); #1;
    fb_if.char_valid = 1'b0;
    n_cmp++;
    if (fb_if.mem_re !== 1'b1) begin
      n_err++;
      $display("FAIL midwrite_read: got mem_re=%b required 1", fb_if.mem_re);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({fb_if.char_ready, fb_if.busy, fb_if.mem_re, fb_if.mem_we, fb_if.mem_addr, fb_if.mem_wdata,
         fb_if.cursor_row, fb_if.cursor_col} !== 49'd0) begin
      n_err++;
      $display("FAIL midwrite_reset: got rdy=%b busy=%b re=%b we=%b addr=%h wdata=%h cursor=(%0d,%0d) required all zero",
               fb_if.char_ready, fb_if.busy, fb_if.mem_re, fb_if.mem_we, fb_if.mem_addr, fb_if.mem_wdata,
               fb_if.cursor_row, fb_if.cursor_col);
    end
    saw_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (fb_if.mem_we !== 1'b0) saw_we = 1'b1;
    end
    reset = 1'b1;
    #1;
    if (fb_if.mem_we !== 1'b0) saw_we = 1'b1;
    m_row = 0;
    m_col = 0;
    n_cmp++;
    if ({saw_we, fb_if.char_ready, fb_if.busy, fb_if.cursor_row, fb_if.cursor_col} !== {1'b0, 1'b1, 1'b0, 13'd0}) begin
      n_err++;
      $display("FAIL midwrite_release: got we_seen=%b rdy=%b busy=%b cursor=(%0d,%0d) required 0 1 0 (0,0)",
               saw_we, fb_if.char_ready, fb_if.busy, fb_if.cursor_row, fb_if.cursor_col);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({fb_if.mem_we, fb_if.mem_re, fb_if.busy} !== 3'b000) begin
      n_err++;
      $display("FAIL midwrite_idle: got we=%b re=%b busy=%b required 0 0 0",
               fb_if.mem_we, fb_if.mem_re, fb_if.busy);
    end
    send_byte(8'h44, 16'h5A5A);
  endtask

  initial begin
    fb_if.char_valid = 1'b0;
    fb_if.char_data  = 8'h00;
    fb_if.clear_req  = 1'b0;
    fb_if.mem_rdata  = 16'h0000;
    test_reset();
    test_basic();
    test_backspace();
    test_row_end();
    test_wrap();
    test_clear_priority();
    test_back_to_back();
    test_random();
    test_reset_midwrite();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
